// File: rtl/mul_hilo_sequencer.sv
// -----------------------------------------------------------------------------
// mul_hilo_sequencer
//
// Issue/writeback stage for an external combinational radix-4 Booth multiplier
// (signed 32x32 -> 64). A start latches the operands onto mul_m/mul_q and
// holds them there for LATENCY cycles. The block then samples mul_product,
// applies the unsigned correction for MULTU, and writes the result into HI/LO.
// It also serves MTHI/MTLO writes, and stalls MFHI/MFLO reads while a multiply
// is in flight.
//
// Optional build macro: MUL_EARLY_ZERO_EN
//   When defined, a start with a zero operand writes HI=LO=0 at the start edge
//   itself and pulses done on the next cycle, without entering WAIT.
//
// Ports:
//   clk          system clock, rising-edge
//   reset        synchronous reset, active-high
//   start        one-cycle multiply request (sampled only while busy=0)
//   signed_op    1 = MULT, 0 = MULTU
//   m_in, q_in   operands
//   mul_m, mul_q registered operands driven to the multiplier
//   mul_product  signed 64-bit product from the multiplier
//   mthi, mtlo   write wdata into HI / LO (ignored while busy)
//   wdata        MTHI/MTLO data
//   busy         multiply in flight
//   done         one-cycle pulse; HI/LO hold the new result
//   hi_out       current HI
//   lo_out       current LO
//   stall        busy & (mfhi_req | mflo_req)
//   mfhi_req     datapath wants HI this cycle
//   mflo_req     datapath wants LO this cycle
// -----------------------------------------------------------------------------
module mul_hilo_sequencer #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] m_in,
    input  logic [31:0] q_in,
    output logic [31:0] mul_m,
    output logic [31:0] mul_q,
    input  logic [63:0] mul_product,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        stall,
    input  logic        mfhi_req,
    input  logic        mflo_req
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // The counter counts the remaining hold edges; capture happens at the
    // edge where it reads zero, so loading LATENCY-1 places the capture
    // LATENCY edges after the start edge.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] m_q, m_d;
    logic [31:0] q_q, q_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [63:0] result;

    // The multiplier treats both operands as signed. For MULTU, an operand
    // with bit 31 set was interpreted as (value - 2^32), so the missing
    // 2^32 * other_operand term is added back (modulo 2^64).
    always_comb begin
        result = mul_product;
        if (!sign_q) begin
            result = mul_product
                   + (m_q[31] ? {q_q, 32'b0} : 64'b0)
                   + (q_q[31] ? {m_q, 32'b0} : 64'b0);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    m_d    = m_in;
                    q_d    = q_in;
                    sign_d = signed_op;
`ifdef MUL_EARLY_ZERO_EN
                    // Zero operand: result is known now, so any MTHI/MTLO
                    // in the same cycle is overridden by the product write.
                    if ((m_in == 32'b0) || (q_in == 32'b0)) begin
                        hi_d   = 32'b0;
                        lo_d   = 32'b0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
`else
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
`endif
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    hi_d    = result[63:32];
                    lo_d    = result[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            m_q     <= 32'b0;
            q_q     <= 32'b0;
            sign_q  <= 1'b0;
            hi_q    <= 32'b0;
            lo_q    <= 32'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign mul_m  = m_q;
    assign mul_q  = q_q;
    assign busy   = (state_q == WAIT);
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign stall  = busy & (mfhi_req | mflo_req);

endmodule

// File: tb/tb_mul_hilo_sequencer.sv
module tb_mul_hilo_sequencer;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset, start, signed_op, mthi, mtlo, mfhi_req, mflo_req;
    logic [31:0] m_in, q_in, wdata;
    logic [31:0] mul_m, mul_q, hi_out, lo_out;
    logic [63:0] mul_product;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the external Booth multiplier: signed 32x32 -> 64.
    logic signed [63:0] sm, sq;
    assign sm = {{32{mul_m[31]}}, mul_m};
    assign sq = {{32{mul_q[31]}}, mul_q};
    assign mul_product = sm * sq;

    mul_hilo_sequencer #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .m_in(m_in), .q_in(q_in), .mul_m(mul_m), .mul_q(mul_q),
        .mul_product(mul_product), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
        .stall(stall), .mfhi_req(mfhi_req), .mflo_req(mflo_req)
    );

    typedef struct {
        string       name;
        logic        sop;
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply and wait (bounded) for done. Returns edges from the
    // start edge to the edge that raised done, and cycles seen with busy=1.
    task automatic issue(input logic sop, input logic [31:0] m, input logic [31:0] q,
                         output int lat, output int nbusy);
        start = 1'b1; signed_op = sop; m_in = m; q_in = q;
        step();
        start = 1'b0;
        lat = 0; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
    endtask

    int lat, nbusy;

    initial begin
        vecs[0] = '{"t1_signed_7x6",   1'b1, 32'd7,        32'd6,        32'h0,        32'h2A,       LAT};
        vecs[1] = '{"t2_signed_m3x5",  1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, LAT};
        vecs[2] = '{"t3_unsigned_ffx2",1'b0, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, LAT};
        vecs[3] = '{"unsigned_ffxff",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        LAT};
        vecs[4] = '{"signed_m1xm1",    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        LAT};
        vecs[5] = '{"unsigned_8x8",    1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        LAT};
`ifdef MUL_EARLY_ZERO_EN
        vecs[6] = '{"t6_zero_operand", 1'b1, 32'h0,        32'h1234,     32'h0,        32'h0,        0};
`else
        vecs[6] = '{"t6_zero_operand", 1'b1, 32'h0,        32'h1234,     32'h0,        32'h0,        LAT};
`endif

        reset = 1'b1; start = 0; signed_op = 0; m_in = 0; q_in = 0;
        mthi = 0; mtlo = 0; wdata = 0; mfhi_req = 0; mflo_req = 0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_outputs", {busy, done, stall, mul_m, mul_q}, 67'b0);
        chk("reset_hilo", {hi_out, lo_out}, 64'b0);
        $display("reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi_out, lo_out);

        // Table vectors, issued back-to-back: each start lands in the
        // previous done cycle.
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].sop, vecs[i].m, vecs[i].q, lat, nbusy);
            $display("%s: m=%h q=%h hi=%h lo=%h lat=%0d busy_cycles=%0d",
                     vecs[i].name, vecs[i].m, vecs[i].q, hi_out, lo_out, lat, nbusy);
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
            chk({vecs[i].name, "_busy_cycles"}, 64'(nbusy), 64'(vecs[i].exp_lat));
            chk({vecs[i].name, "_busy_in_done"}, {63'b0, busy}, 64'b0);
            chk({vecs[i].name, "_hilo"}, {hi_out, lo_out}, {vecs[i].exp_hi, vecs[i].exp_lo});
            chk({vecs[i].name, "_mul_m"}, {32'b0, mul_m}, {32'b0, vecs[i].m});
        end
        step();
        chk("done_one_cycle", {63'b0, done}, 64'b0);

        // Start and MTHI while busy are both ignored.
        start = 1'b1; signed_op = 1'b1; m_in = 32'd9; q_in = 32'd9;
        step();
        start = 1'b0;
        step();
        start = 1'b1; m_in = 32'd1; q_in = 32'd1; mthi = 1'b1; wdata = 32'hDEAD;
        step();
        start = 1'b0; mthi = 1'b0;
        chk("t4_operand_held", {mul_m, mul_q}, {32'd9, 32'd9});
        lat = 0;
        while (!done && lat < 40) begin step(); lat++; end
        $display("t4_ignore_busy: hi=%h lo=%h", hi_out, lo_out);
        chk("t4_latency_after_ignore", 64'(lat), 64'(LAT - 2));
        chk("t4_hilo", {hi_out, lo_out}, {32'h0, 32'h51});
        step();
        chk("t4_done_pulse_once", {63'b0, done}, 64'b0);
        chk("t4_no_second_mul", {63'b0, busy}, 64'b0);
        mthi = 1'b1; wdata = 32'hDEAD;
        step();
        mthi = 1'b0;
        $display("t4_mthi: hi=%h lo=%h", hi_out, lo_out);
        chk("t4_mthi_idle", {hi_out, lo_out}, {32'h0000DEAD, 32'h51});
        mtlo = 1'b1; wdata = 32'h00C0FFEE;
        step();
        mtlo = 1'b0;
        chk("mtlo_idle", {hi_out, lo_out}, {32'h0000DEAD, 32'h00C0FFEE});

        // Stall, then reset in the middle of a multiply.
        mflo_req = 1'b1;
        #1;
        chk("stall_idle", {63'b0, stall}, 64'b0);
        start = 1'b1; signed_op = 1'b1; m_in = 32'd3; q_in = 32'd3;
        step();
        start = 1'b0;
        chk("t5_stall_busy", {63'b0, stall}, 64'b1);
        mflo_req = 1'b0; mfhi_req = 1'b1;
        #1;
        chk("stall_mfhi_busy", {63'b0, stall}, 64'b1);
        mfhi_req = 1'b0;
        #1;
        chk("stall_no_req", {63'b0, stall}, 64'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("t5_reset_mid: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi_out, lo_out);
        chk("t5_busy_after_reset", {63'b0, busy}, 64'b0);
        chk("t5_hilo_after_reset", {hi_out, lo_out}, 64'b0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) lat++;
            step();
        end
        chk("t5_no_done_after_abort", 64'(lat), 64'b0);
        chk("t5_hilo_still_zero", {hi_out, lo_out}, 64'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
